// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports with write bypass, two write ports, busy scoreboard, optional HI/LO.
// Latency: reads and busy lookups are 0 cycles; writes, busy set/clear and HI/LO updates land at the next rising edge.
// Backpressure: none; every write, SetBusy and HiLoWrite is accepted unconditionally on the edge where it is presented.
module reg_file_mp #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter bit HILO_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WN,
    input  logic [WIDTH-1:0]  WD,
    input  logic              RegWrite2,
    input  logic [ADDR_W-1:0] WN2,
    input  logic [WIDTH-1:0]  WD2,
    input  logic              SetBusy,
    input  logic [ADDR_W-1:0] BusyN,
    input  logic              HiLoWrite,
    input  logic [WIDTH-1:0]  HiIn,
    input  logic [WIDTH-1:0]  LoIn,
    output logic [WIDTH-1:0]  HiOut,
    output logic [WIDTH-1:0]  LoOut
);

    localparam int N = 1 << ADDR_W;

    // Entry 0 is hard-wired zero, so storage and busy bits start at index 1.
    logic [WIDTH-1:0] regs [1:N-1];
    logic [N-1:1]     busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Register storage: port B is checked first so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < N; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < N; k++) begin
                if (RegWrite2 && (WN2 == ADDR_W'(k))) begin
                    regs[k] <= WD2;
                end else if (RegWrite && (WN == ADDR_W'(k))) begin
                    regs[k] <= WD;
                end
            end
        end
    end

    // Busy scoreboard: a new SetBusy beats a completing write to the same entry (younger request wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int k = 1; k < N; k++) begin
                if (SetBusy && (BusyN == ADDR_W'(k))) begin
                    busy_q[k] <= 1'b1;
                end else if ((RegWrite && (WN == ADDR_W'(k))) ||
                             (RegWrite2 && (WN2 == ADDR_W'(k)))) begin
                    busy_q[k] <= 1'b0;
                end
            end
        end
    end

    // HI/LO pair: with HILO_EN=0 the enable is constant-false and the flops collapse to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (HILO_EN && HiLoWrite) begin
            hi_q <= HiIn;
            lo_q <= LoIn;
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;

    // Read port 1: bypass uses the same B-over-A priority as the write collision.
    always_comb begin
        RD1 = '0;
        if (RN1 != '0) begin
            if (RegWrite2 && (WN2 == RN1)) begin
                RD1 = WD2;
            end else if (RegWrite && (WN == RN1)) begin
                RD1 = WD;
            end else begin
                for (int k = 1; k < N; k++) begin
                    if (RN1 == ADDR_W'(k)) RD1 = regs[k];
                end
            end
        end
    end

    // Read port 2: identical bypass and priority to port 1.
    always_comb begin
        RD2 = '0;
        if (RN2 != '0) begin
            if (RegWrite2 && (WN2 == RN2)) begin
                RD2 = WD2;
            end else if (RegWrite && (WN == RN2)) begin
                RD2 = WD;
            end else begin
                for (int k = 1; k < N; k++) begin
                    if (RN2 == ADDR_W'(k)) RD2 = regs[k];
                end
            end
        end
    end

    // Busy lookup: registered bit only, deliberately not bypassed; entry 0 is never busy.
    always_comb begin
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (RN1 == ADDR_W'(k)) Busy1 = busy_q[k];
            if (RN2 == ADDR_W'(k)) Busy2 = busy_q[k];
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RN1, RN2, WN, WN2, BusyN;
    logic [31:0] RD1, RD2, WD, WD2, HiIn, LoIn, HiOut, LoOut;
    logic        Busy1, Busy2, RegWrite, RegWrite2, SetBusy, HiLoWrite;

    reg_file_mp #(.WIDTH(32), .ADDR_W(5), .HILO_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2),
        .Busy1(Busy1), .Busy2(Busy2),
        .RegWrite(RegWrite), .WN(WN), .WD(WD),
        .RegWrite2(RegWrite2), .WN2(WN2), .WD2(WD2),
        .SetBusy(SetBusy), .BusyN(BusyN),
        .HiLoWrite(HiLoWrite), .HiIn(HiIn), .LoIn(LoIn),
        .HiOut(HiOut), .LoOut(LoOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rn1, rn2;
        logic        we;  logic [4:0] wn;  logic [31:0] wd;
        logic        we2; logic [4:0] wn2; logic [31:0] wd2;
        logic        sb;  logic [4:0] bn;
        logic        hw;  logic [31:0] hi, lo;
    } stim_t;

    typedef struct {
        string       nm;
        logic [31:0] rd1, rd2, hi, lo;
        logic        b1, b2;
    } exp_t;

    // Reference model: architectural state as plain arrays.
    logic [31:0] mem_m [0:31];
    bit          busy_m [0:31];
    logic [31:0] hi_m, lo_m;

    exp_t exp_q [$];
    event mon_ev;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.rn1 = '0; s.rn2 = '0;
        s.we = 1'b0;  s.wn = '0;  s.wd = '0;
        s.we2 = 1'b0; s.wn2 = '0; s.wd2 = '0;
        s.sb = 1'b0;  s.bn = '0;
        s.hw = 1'b0;  s.hi = '0;  s.lo = '0;
        return s;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) begin
            mem_m[k]  = '0;
            busy_m[k] = 1'b0;
        end
        hi_m = '0;
        lo_m = '0;
    endfunction

    // Value a read must return: the value that will be stored at the next edge.
    function automatic logic [31:0] model_read(input logic [4:0] rn, input stim_t s);
        if (rn == 0) return '0;
        if (s.we2 && s.wn2 == rn) return s.wd2;
        if (s.we && s.wn == rn) return s.wd;
        return mem_m[rn];
    endfunction

    // Edge update: writes in order A then B (B overwrites), clears before set (set wins).
    function automatic void model_edge(input stim_t s);
        if (s.we && s.wn != 0) begin mem_m[s.wn] = s.wd; busy_m[s.wn] = 1'b0; end
        if (s.we2 && s.wn2 != 0) begin mem_m[s.wn2] = s.wd2; busy_m[s.wn2] = 1'b0; end
        if (s.sb && s.bn != 0) busy_m[s.bn] = 1'b1;
        if (s.hw) begin hi_m = s.hi; lo_m = s.lo; end
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: pops each expectation and compares it with what the DUT is presenting now.
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk(e.nm, "RD1", RD1, e.rd1);
                chk(e.nm, "RD2", RD2, e.rd2);
                chk(e.nm, "Busy1", {31'b0, Busy1}, {31'b0, e.b1});
                chk(e.nm, "Busy2", {31'b0, Busy2}, {31'b0, e.b2});
                chk(e.nm, "HiOut", HiOut, e.hi);
                chk(e.nm, "LoOut", LoOut, e.lo);
            end
        end
    end

    // One cycle: drive after the edge, queue the expected pre-edge response, then advance the model at the edge.
    task automatic do_cycle(input stim_t s, input string nm);
        exp_t e;
        rst_n = s.rst_n; RN1 = s.rn1; RN2 = s.rn2;
        RegWrite = s.we;   WN = s.wn;   WD = s.wd;
        RegWrite2 = s.we2; WN2 = s.wn2; WD2 = s.wd2;
        SetBusy = s.sb; BusyN = s.bn;
        HiLoWrite = s.hw; HiIn = s.hi; LoIn = s.lo;
        if (!s.rst_n) model_reset();
        #1;
        e.nm  = nm;
        e.rd1 = model_read(s.rn1, s);
        e.rd2 = model_read(s.rn2, s);
        e.b1  = busy_m[s.rn1];
        e.b2  = busy_m[s.rn2];
        e.hi  = hi_m;
        e.lo  = lo_m;
        exp_q.push_back(e);
        pushed++;
        -> mon_ev;
        @(posedge clk);
        if (s.rst_n) model_edge(s);
        #1;
    endtask

    initial begin
        stim_t s;
        model_reset();
        rst_n = 1'b0;

        // Reset then read.
        s = idle(); s.rst_n = 1'b0; s.rn1 = 5'd5; s.rn2 = 5'd31;
        do_cycle(s, "reset_read");
        s = idle(); s.rn1 = 5'd5; s.rn2 = 5'd31;
        do_cycle(s, "post_reset");

        // Write with same-cycle bypass, then stored value.
        s = idle(); s.we = 1'b1; s.wn = 5'd7; s.wd = 32'hDEADBEEF; s.rn1 = 5'd7; s.rn2 = 5'd8;
        do_cycle(s, "bypass_a");
        s = idle(); s.rn1 = 5'd7;
        do_cycle(s, "stored_a");

        // Dual-port collision: port B wins both for bypass and storage.
        s = idle(); s.we = 1'b1; s.wn = 5'd3; s.wd = 32'h11;
        s.we2 = 1'b1; s.wn2 = 5'd3; s.wd2 = 32'h22; s.rn1 = 5'd3; s.rn2 = 5'd3;
        do_cycle(s, "collide");
        s = idle(); s.rn1 = 5'd3; s.rn2 = 5'd7;
        do_cycle(s, "collide_stored");

        // Zero register ignores writes and busy set.
        s = idle(); s.we = 1'b1; s.wn = 5'd0; s.wd = 32'hFFFFFFFF; s.sb = 1'b1; s.bn = 5'd0;
        s.we2 = 1'b1; s.wn2 = 5'd0; s.wd2 = 32'h12345678;
        do_cycle(s, "zero_wr");
        s = idle();
        do_cycle(s, "zero_after");

        // Scoreboard: set, set+clear (set wins), clear, then observe.
        s = idle(); s.sb = 1'b1; s.bn = 5'd9; s.rn1 = 5'd9;
        do_cycle(s, "sb_set");
        s = idle(); s.we2 = 1'b1; s.wn2 = 5'd9; s.wd2 = 32'hA5A5; s.sb = 1'b1; s.bn = 5'd9; s.rn1 = 5'd9;
        do_cycle(s, "sb_set_clr");
        s = idle(); s.we2 = 1'b1; s.wn2 = 5'd9; s.wd2 = 32'h5A5A; s.rn1 = 5'd9; s.rn2 = 5'd9;
        do_cycle(s, "sb_clr");
        s = idle(); s.rn1 = 5'd9;
        do_cycle(s, "sb_cleared");

        // HI/LO: no bypass, then asynchronous reset clears it mid-cycle.
        s = idle(); s.hw = 1'b1; s.hi = 32'h1; s.lo = 32'h2;
        do_cycle(s, "hilo_wr");
        s = idle(); s.rn1 = 5'd7; s.rn2 = 5'd3;
        do_cycle(s, "hilo_after");
        s = idle(); s.rst_n = 1'b0; s.rn1 = 5'd7; s.rn2 = 5'd3;
        s.we = 1'b1; s.wn = 5'd4; s.wd = 32'hCAFE; s.sb = 1'b1; s.bn = 5'd4;
        do_cycle(s, "reset_mid");
        s = idle(); s.rn1 = 5'd4; s.rn2 = 5'd7;
        do_cycle(s, "reset_release");

        // Randomized traffic with occasional resets; reads often aimed at a write address.
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.we  = $urandom_range(0, 1) == 1; s.wn  = 5'($urandom); s.wd  = $urandom;
            s.we2 = $urandom_range(0, 2) == 0; s.wn2 = 5'($urandom); s.wd2 = $urandom;
            if ($urandom_range(0, 5) == 0) s.wn2 = s.wn;
            s.sb = $urandom_range(0, 2) == 0;  s.bn = 5'($urandom);
            if ($urandom_range(0, 3) == 0) s.bn = s.wn;
            s.hw = $urandom_range(0, 4) == 0;  s.hi = $urandom; s.lo = $urandom;
            case ($urandom_range(0, 3))
                0: s.rn1 = s.wn;
                1: s.rn1 = s.wn2;
                default: s.rn1 = 5'($urandom);
            endcase
            s.rn2 = ($urandom_range(0, 2) == 0) ? s.bn : 5'($urandom);
            do_cycle(s, "random");
        end

        #2;
        chk("drain", "popped", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
